// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter with a ready/valid word input and a one-word
// holding buffer, so back-to-back words stream out with no idle cycle.
// Latency: a word accepted at edge N from idle drives its first bit after N.
// Backpressure: a_ready = !hold_full; a word offered while not ready is ignored.
//
// Optional feature macro: P2S_PARITY_EN
//   When defined, each frame is followed by one even-parity bit
//   (XOR of the data bits), and serial_end moves onto that bit.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   a, a_valid    - parallel word and its valid qualifier
//   a_ready       - word can be accepted this cycle (combinational from regs)
//   d, d_valid    - serial bit and its qualifier (registered)
//   serial_start  - first bit cycle of a frame (registered)
//   serial_end    - last cycle of a frame (registered)
//   busy          - shifter active or holding buffer occupied
module p2s_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic             a_valid,
   output logic             a_ready,
   output logic             d,
   output logic             d_valid,
   output logic             serial_start,
   output logic             serial_end,
   output logic             busy
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef P2S_PARITY_EN
   localparam bit            PAR  = 1'b1;
`else
   localparam bit            PAR  = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1
`ifdef P2S_PARITY_EN
      ,
      PARITY = 2'd2
`endif
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [WIDTH-1:0] hold, hold_nxt;
   logic             hold_full, hold_full_nxt;
   logic             d_nxt, d_valid_nxt, start_nxt, end_nxt;
`ifdef P2S_PARITY_EN
   logic             par, par_nxt;
`endif

   logic             accept;
   logic             frame_end;
   logic             load;
   logic [WIDTH-1:0] load_word;
   logic [WIDTH-1:0] ordered;

   // Put the word into transmit order so the shifter always emits bit 0.
   function automatic logic [WIDTH-1:0] tx_order(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] r;
      r = w;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            r[i] = w[WIDTH-1-i];
         end
      end
      return r;
   endfunction

   assign a_ready = !hold_full;
   assign busy    = d_valid || hold_full;
   assign accept  = a_valid && !hold_full;
   assign ordered = tx_order(load_word);

`ifdef P2S_PARITY_EN
   assign frame_end = (state == PARITY);
`else
   assign frame_end = (state == SHIFT) && (cnt == LAST);
`endif

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      shreg_nxt     = shreg;
      hold_nxt      = hold;
      hold_full_nxt = hold_full;
      d_nxt         = 1'b0;
      d_valid_nxt   = 1'b0;
      start_nxt     = 1'b0;
      end_nxt       = 1'b0;
      load          = 1'b0;
      load_word     = a;
`ifdef P2S_PARITY_EN
      par_nxt       = par;
`endif

      if (state == IDLE || frame_end) begin
         // Frame boundary: a buffered word has priority over a new one
         // (a new one cannot be accepted while the buffer is full anyway).
         if (hold_full) begin
            load          = 1'b1;
            load_word     = hold;
            hold_full_nxt = 1'b0;
         end else if (accept) begin
            load          = 1'b1;
            load_word     = a;
         end else begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
         end
      end else begin
         if (accept) begin
            hold_nxt      = a;
            hold_full_nxt = 1'b1;
         end
         if (cnt != LAST) begin
            cnt_nxt     = cnt + 1'b1;
            d_nxt       = shreg[0];
            shreg_nxt   = shreg >> 1;
            d_valid_nxt = 1'b1;
            end_nxt     = !PAR && ((cnt + 1'b1) == LAST);
         end
`ifdef P2S_PARITY_EN
         else begin
            state_nxt   = PARITY;
            d_nxt       = par;
            d_valid_nxt = 1'b1;
            end_nxt     = 1'b1;
         end
`endif
      end

      if (load) begin
         state_nxt   = SHIFT;
         cnt_nxt     = '0;
         d_nxt       = ordered[0];
         shreg_nxt   = ordered >> 1;
         d_valid_nxt = 1'b1;
         start_nxt   = 1'b1;
         end_nxt     = !PAR && (WIDTH == 1);
`ifdef P2S_PARITY_EN
         par_nxt     = ^load_word;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         shreg        <= '0;
         hold         <= '0;
         hold_full    <= 1'b0;
         d            <= 1'b0;
         d_valid      <= 1'b0;
         serial_start <= 1'b0;
         serial_end   <= 1'b0;
`ifdef P2S_PARITY_EN
         par          <= 1'b0;
`endif
      end else begin
         cnt          <= cnt_nxt;
         shreg        <= shreg_nxt;
         hold         <= hold_nxt;
         hold_full    <= hold_full_nxt;
         d            <= d_nxt;
         d_valid      <= d_valid_nxt;
         serial_start <= start_nxt;
         serial_end   <= end_nxt;
`ifdef P2S_PARITY_EN
         par          <= par_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: three instances (8-bit LSB-first, 8-bit MSB-first,
// 1-bit) share one stimulus; each is compared every cycle against a queue of
// expected serial records built from whole accepted words.
module tb_p2s_serializer;

`ifdef P2S_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int N = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a   = 8'h00;
   logic       a_valid = 1'b0;

   logic [N-1:0] o_rdy, o_d, o_dv, o_s, o_e, o_b;

   int errors = 0;
   int checks = 0;

   int wid  [N] = '{8, 8, 1};
   int msbf [N] = '{0, 1, 0};

   // Expected records {start, end, d}, one per serial cycle, per instance.
   logic [2:0] mq [N][64];
   int         mh [N];
   int         mc [N];

   always #5 clk = ~clk;

   p2s_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(o_rdy[0]),
      .d(o_d[0]), .d_valid(o_dv[0]), .serial_start(o_s[0]),
      .serial_end(o_e[0]), .busy(o_b[0]));

   p2s_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(o_rdy[1]),
      .d(o_d[1]), .d_valid(o_dv[1]), .serial_start(o_s[1]),
      .serial_end(o_e[1]), .busy(o_b[1]));

   p2s_serializer #(.WIDTH(1), .MSB_FIRST(1'b0)) u_w1 (
      .clk(clk), .rst(rst), .a(a[0:0]), .a_valid(a_valid), .a_ready(o_rdy[2]),
      .d(o_d[2]), .d_valid(o_dv[2]), .serial_start(o_s[2]),
      .serial_end(o_e[2]), .busy(o_b[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int frame_len(input int i);
      return wid[i] + PAR;
   endfunction

   task automatic push_rec(input int i, input logic [2:0] r);
      mq[i][(mh[i] + mc[i]) % 64] = r;
      mc[i]++;
   endtask

   task automatic push_word(input int i, input logic [7:0] w);
      logic b;
      logic p;
      p = 1'b0;
      for (int k = 0; k < wid[i]; k++) begin
         b = (msbf[i] != 0) ? w[wid[i]-1-k] : w[k];
         p = p ^ b;
         push_rec(i, {(k == 0), ((k == wid[i]-1) && (PAR == 0)), b});
      end
      if (PAR != 0) push_rec(i, {1'b0, 1'b1, p});
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         mh[i] = 0;
         mc[i] = 0;
      end
   endtask

   // Compare every instance against the front of its expected queue.
   task automatic check_all();
      logic [2:0] r;
      for (int i = 0; i < N; i++) begin
         r = (mc[i] > 0) ? mq[i][mh[i]] : 3'b000;
         chk($sformatf("u%0d_d_valid", i), o_dv[i], (mc[i] > 0));
         chk($sformatf("u%0d_d", i),       o_d[i],  r[0]);
         chk($sformatf("u%0d_start", i),   o_s[i],  r[2]);
         chk($sformatf("u%0d_end", i),     o_e[i],  r[1]);
         chk($sformatf("u%0d_a_ready", i), o_rdy[i], (mc[i] <= frame_len(i)));
         chk($sformatf("u%0d_busy", i),    o_b[i],  (mc[i] > 0));
      end
   endtask

   // One cycle: check at the falling edge, drive inputs, advance the model
   // at the rising edge. acc0 reports whether instance 0 took the word.
   task automatic step(input logic v, input logic [7:0] w, output logic acc0);
      logic acc [N];
      @(negedge clk);
      check_all();
      a_valid = v;
      a       = w;
      for (int i = 0; i < N; i++) acc[i] = v && (mc[i] <= frame_len(i));
      acc0 = acc[0];
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (mc[i] > 0) begin
            mh[i] = (mh[i] + 1) % 64;
            mc[i]--;
         end
         if (acc[i]) push_word(i, w);
      end
   endtask

   task automatic idle(input int n);
      logic dummy;
      for (int k = 0; k < n; k++) step(1'b0, 8'h00, dummy);
   endtask

   task automatic send_word(input logic [7:0] w);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 40) begin
         step(1'b1, w, acc);
         tries++;
      end
      chk("send_word_accepted", acc, 1'b1);
   endtask

   task automatic reset_now();
      @(negedge clk);
      rst     = 1'b1;
      a_valid = 1'b0;
      #1;
      model_clear();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rst%0d_d", i),       o_d[i],   1'b0);
         chk($sformatf("rst%0d_d_valid", i), o_dv[i],  1'b0);
         chk($sformatf("rst%0d_start", i),   o_s[i],   1'b0);
         chk($sformatf("rst%0d_end", i),     o_e[i],   1'b0);
         chk($sformatf("rst%0d_busy", i),    o_b[i],   1'b0);
         chk($sformatf("rst%0d_a_ready", i), o_rdy[i], 1'b1);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic dummy;
      model_clear();
      reset_now();

      // Single word, then idle long enough to see the frame drain.
      send_word(8'b1101_0011);
      idle(12);

      // Back-to-back with a third word pushed against backpressure.
      send_word(8'hA5);
      send_word(8'h3C);
      send_word(8'h5A);
      idle(30);

      // Reset in the middle of a frame with the holding buffer full.
      send_word(8'hFF);
      send_word(8'h77);
      idle(2);
      reset_now();
      send_word(8'h01);
      idle(12);

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         step(($urandom_range(0, 3) != 0), 8'($urandom), dummy);
      end
      idle(30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/p2s_serializer.md
# p2s_serializer

Parametrised parallel-to-serial converter with a ready/valid input, a one-word holding buffer for gap-free back-to-back streaming, and selectable bit order. Sits between a word-wide datapath and a single-wire serial link. It drives per-word `serial_start`/`serial_end` framing strobes. It is the successor to the fixed 8-bit, LSB-first, `bgn`-triggered serializer.

## Interface
- `WIDTH`, 8: data word width, ≥1.
- `MSB_FIRST`, 0: 0 = bit 0 shifted first; 1 = bit WIDTH-1 shifted first.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `a` input WIDTH: parallel word.
- `a_valid` input 1: `a` holds a word to send.
- `a_ready` output 1: block can accept a word this cycle.
- `d` output 1: serial data bit.
- `d_valid` output 1: `d` carries a bit this cycle.
- `serial_start` output 1: high during the first bit cycle of a word.
- `serial_end` output 1: high during the last bit cycle of a word.
- `busy` output 1: shifter active or holding buffer full.

## Operation
- Datapath:
  - Shift register with a bit counter (`$clog2(WIDTH+1)` bits).
  - One-entry holding register `hold` with flag `hold_full`.
- `a_ready = !hold_full`. This is combinational from a register and does not depend on `a_valid`.
- A word is accepted on a rising edge with `a_valid && a_ready`. `a` is ignored on all other cycles.
- Routing of an accepted word:
  - If the shifter is in IDLE, or is in its final bit cycle, the word loads straight into the shifter.
  - Otherwise it goes into `hold` and `hold_full` is set.
- At the end of the final bit cycle:
  - If `hold_full`, `hold` moves to the shifter, `hold_full` clears, and there is no idle cycle.
  - Otherwise, if a word is accepted in that same cycle, it loads directly.
  - Otherwise the shifter returns to IDLE.
- FSM:
  - IDLE → SHIFT on a load.
  - SHIFT stays in SHIFT for WIDTH bit cycles.
  - From the last bit cycle, SHIFT returns to SHIFT on a reload, or to IDLE.
  - With parity enabled, SHIFT → PARITY (1 cycle) → SHIFT/IDLE.
- Bit cycle k (k = 0..WIDTH-1) outputs `a[k]` when MSB_FIRST=0, or `a[WIDTH-1-k]` when MSB_FIRST=1.
- `d_valid` is 1 in SHIFT/PARITY and 0 in IDLE. `d` is 0 whenever `d_valid` is 0.
- `serial_start` is high in bit cycle 0.
- `serial_end` is high in the last cycle of the word: bit WIDTH-1, or the parity cycle when parity is enabled.
- WIDTH=1: `serial_start` and `serial_end` are both high in the single bit cycle.
- `busy = d_valid || hold_full`.
- Holding `a_valid` high while `a_ready` is 0 has no effect. The word must be re-presented.

## Timing
- Reset values:
  - `d`=0, `d_valid`=0, `serial_start`=0, `serial_end`=0, `busy`=0.
  - `hold_full`=0, so `a_ready`=1.
  - FSM in IDLE, counter at 0.
- Latency: a word accepted at edge N from IDLE puts bit 0 on `d` in the cycle after edge N.
- Throughput: one word per WIDTH cycles (WIDTH+1 with parity), with `d_valid` continuously high while words keep arriving.
- All outputs are registered except `a_ready` and `busy`, which are combinational from registers.
- Reset asserted mid-word:
  - Shifter and `hold` are discarded immediately, without waiting for a clock edge.
  - No `serial_end` is issued for the truncated word.
  - After `rst` deasserts, the next accepted word starts a fresh frame.

## Configuration
- `P2S_PARITY_EN` defined:
  - One extra PARITY cycle follows each word's data bits.
  - `d` = even parity, i.e. XOR of the WIDTH data bits.
  - `d_valid`=1 in that cycle, and `serial_end` moves to it.
  - Frame length is WIDTH+1.
- `P2S_PARITY_EN` undefined: no PARITY state, and frame length is WIDTH.

## Test plan
- **Single word, LSB first.** WIDTH=8, MSB_FIRST=0, one word `a`=8'b11010011 → `d` = 1,1,0,0,1,0,1,1 over 8 cycles. `serial_start` high in cycle 1 only, `serial_end` high in cycle 8 only, then `d_valid`=0 and `busy`=0.
- **MSB first.** Same word with MSB_FIRST=1 → `d` = 1,1,0,1,0,0,1,1.
- **Back-to-back.** Send 8'hA5 then 8'h3C with `a_valid` held high → 16 contiguous `d_valid` cycles. `serial_start` at cycles 1 and 9, `serial_end` at cycles 8 and 16. `a_ready` drops after the second accept and returns to 1 when `hold` drains.
- **Backpressure.** Offer a third word while `hold_full` → `a_ready`=0 and the word is not accepted. Once accepted later, it is output intact after the second word.
- **Reset mid-word.** Assert `rst` in bit cycle 3 of 8'hFF with `hold` full → all outputs 0 immediately and `a_ready`=1. After release, 8'h01 serializes alone as 1,0,0,0,0,0,0,0.
- **Parity.** With `P2S_PARITY_EN` defined and `a`=8'b11010011 → 9-cycle frame whose 9th bit is 1 (five ones), with `serial_end` on cycle 9.
